// File: rtl/spi_write_scheduler_pkg.sv
// Shared types, constants and helpers for the SPI write scheduler.
package spi_sched_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DELAY_BASE = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_CHECK = 3'd2,
        ST_SEND  = 3'd3,
        ST_END   = 3'd4
    } egress_state_e;

    // Pacing interval: fixed base plus a power-of-two programmable part.
    function automatic logic [31:0] calc_delay(input logic [31:0] base, input logic [3:0] rate_shift);
        return base + (32'd1 << rate_shift);
    endfunction

endpackage

// File: rtl/spi_write_scheduler_if.sv
// Producer handshake plus fifo_spi write port bundled as one interface.
interface spi_write_scheduler_if
    import spi_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DATA_W  = DEF_DATA_W
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      we;
    logic [DATA_W-1:0]         din;

    // Producer / fifo side drives data and observes grants and writes.
    modport master (output src_valid, output src_data, input src_ready, input we, input din);
    // Scheduler side.
    modport slave  (input src_valid, input src_data, output src_ready, output we, output din);
endinterface

// File: rtl/spi_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the priority pointer wins.
module rr_arbiter #(
    parameter int unsigned NUM_SRC = 2,
    localparam int unsigned PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt
);
    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan from the priority pointer; no grant at all while advance is low.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            idx = PTR_W'((int'(ptr) + k) % int'(NUM_SRC));
            if (advance && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_write_scheduler.sv
// Arbitrates producers into a circular buffer and paces writes into fifo_spi.
module spi_write_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned BUF_DEPTH  = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DELAY_BASE = spi_sched_pkg::DELAY_BASE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [3:0]            rate_shift,
    input  logic                  spi_block,
    spi_write_scheduler_if.slave  bus,
    output logic                  tick,
    output logic [ADDR_W:0]       buf_level,
    output logic [3:0]            state_dbg
);
    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned LVL_W = ADDR_W + 1;

    egress_state_e     state_q, state_d;
    logic [1:0]        blk_sync;
    logic              blocked;
    logic [NUM_SRC-1:0] gnt;
    logic [PTR_W-1:0]  prio_ptr, gnt_idx;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [31:0]       delay_cnt;
    logic              push, pop, full;
    logic              we_q, tick_q;
    logic [DATA_W-1:0] din_q;

    assign blocked   = blk_sync[1];
    assign full      = (level_q == LVL_W'(BUF_DEPTH));
    assign push      = |gnt;
    assign pop       = (state_q == ST_SEND);
    assign bus.src_ready = gnt;
    assign bus.we    = we_q;
    assign bus.din   = din_q;
    assign tick      = tick_q;
    assign buf_level = level_q;
    assign state_dbg = 4'(state_q);

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req     (bus.src_valid),
        .advance (rst_n && !full),
        .ptr     (prio_ptr),
        .gnt     (gnt)
    );

    // Select the granted producer's word and index.
    always_comb begin
        push_data = '0;
        gnt_idx   = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (gnt[i]) begin
                push_data = bus.src_data[i*DATA_W +: DATA_W];
                gnt_idx   = PTR_W'(i);
            end
        end
    end

    // Two-flop synchroniser for spi_block; resets to blocked.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) blk_sync <= 2'b11;
        else        blk_sync <= {blk_sync[0], spi_block};
    end

    // Ingress: priority pointer, write pointer and buffer occupancy.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                prio_ptr <= (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
                wr_ptr   <= wr_ptr + ADDR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Buffer storage; contents are don't-care until written.
    always_ff @(negedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Egress state register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Egress next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en && level_q != '0) state_d = ST_DELAY;
            ST_DELAY: if (delay_cnt >= calc_delay(32'(DELAY_BASE), rate_shift)) state_d = ST_CHECK;
            ST_CHECK: if (!blocked) state_d = ST_SEND;
            ST_SEND:  state_d = ST_END;
            ST_END:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered egress outputs and pacing counter.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            tick_q    <= 1'b0;
            din_q     <= '0;
            delay_cnt <= '0;
        end else begin
            we_q   <= (state_d == ST_SEND);
            tick_q <= (state_d == ST_SEND) || (state_d == ST_END);
            if (state_q == ST_IDLE)       delay_cnt <= '0;
            else if (state_q == ST_DELAY) delay_cnt <= delay_cnt + 32'd1;
            if (state_q == ST_CHECK && !blocked) din_q <= mem[rd_ptr];
        end
    end
endmodule
